// File: rtl/cdc_handshake_rx_ctrl.sv
// cdc_handshake_rx_ctrl
//   Destination-side controller for a 4-phase req/ack multi-bit CDC transfer.
//   src_req goes through a SYNC_STAGES flop chain. The quasi-static src_data
//   bus is captured once, on the IDLE->VALID transition. The captured word is
//   offered on a valid/ready interface. dst_ack is returned to the source, and
//   a request dropped before the word was accepted is flagged.
//
// Ports
//   dst_clk     in   destination clock (rising edge)
//   rst_n       in   asynchronous active-low reset
//   src_req     in   async level request from the source domain
//   src_data    in   async data, held stable by the source during the handshake
//   dst_ack     out  registered ack back to the source domain
//   out_data    out  captured word
//   out_valid   out  out_data valid for the consumer
//   out_ready   in   consumer accepts on out_valid & out_ready
//   proto_err   out  sticky protocol-violation flag
//   err_clr     in   synchronous clear of proto_err (a same-cycle set wins)
//   xfer_count  out  completed transfers, wraps modulo 2^CNT_W
module cdc_handshake_rx_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              dst_clk,
  input  logic              rst_n,
  input  logic              src_req,
  input  logic [DATA_W-1:0] src_data,
  output logic              dst_ack,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              proto_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  xfer_count
);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("cdc_handshake_rx_ctrl: SYNC_STAGES must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_s;

  // Only stage 0 sees the asynchronous src_req. Every later stage samples
  // the stage before it.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], src_req};
  assign req_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // The clear is applied first so that a violation below overrides it.
    err_d   = err_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // src_data has been stable since before src_req rose. It has had at
          // least SYNC_STAGES cycles to settle, so a direct capture is safe.
          data_d  = src_data;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        // The source withdrew its request before the word was taken. Flag it,
        // but still deliver the word.
        if (!req_s) err_d = 1'b1;
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Leave only on req_s=0. A request re-raised early by the source can
        // therefore never be captured twice.
        if (!req_s) begin
          ack_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dst_ack    = ack_q;
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign proto_err  = err_q;
  assign xfer_count = cnt_q;

endmodule
